// File: rtl/sram_1rw_init_ext.sv
// sram_1rw_init_ext: parametrised 1RW synchronous SRAM with a clear sequencer,
// per-lane write mask and a registered, hold-last-read output of latency 1 or 2.
module sram_1rw_init_ext #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 64,
    parameter int LANE_W = 8,
    parameter int RD_LAT = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0,
    localparam int MW = DATA_W / LANE_W
) (
    input  logic              RW0_clk,
    input  logic              RW0_rst_n,
    input  logic [ADDR_W-1:0] RW0_addr,
    input  logic              RW0_en,
    input  logic              RW0_wmode,
    input  logic [MW-1:0]     RW0_wmask,
    input  logic [DATA_W-1:0] RW0_wdata,
    output logic [DATA_W-1:0] RW0_rdata,
    output logic              RW0_rvalid,
    output logic              RW0_ready,
    input  logic              init_req
);
    typedef enum logic {CLEAR, READY} state_t;
    state_t state;
    logic [ADDR_W-1:0] ctr;
    logic [DATA_W-1:0] ram [2**ADDR_W];
    logic acc, wr, rd;
    assign acc = RW0_rst_n && state == READY && RW0_en;
    assign wr = acc && RW0_wmode;
    assign rd = acc && !RW0_wmode;
    always_ff @(posedge RW0_clk) begin
        if (!RW0_rst_n) begin
            state <= CLEAR;
            ctr <= '0;
            RW0_ready <= 1'b0;
        end else if (state == CLEAR) begin
            ctr <= ctr + 1'b1;
            if (ctr == '1) begin
                state <= READY;
                RW0_ready <= 1'b1;
            end
        end else if (init_req) begin
            state <= CLEAR;
            ctr <= '0;
            RW0_ready <= 1'b0;
        end
    end
    // Array has no reset of its own; the clear sequencer initialises it.
    always_ff @(posedge RW0_clk) begin
        if (RW0_rst_n && state == CLEAR)
            ram[ctr] <= INIT_VAL;
        else if (wr)
            for (int i = 0; i < MW; i++)
                if (RW0_wmask[i]) ram[RW0_addr][i*LANE_W +: LANE_W] <= RW0_wdata[i*LANE_W +: LANE_W];
    end
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              p_v;
            logic [DATA_W-1:0] p_d;
            always_ff @(posedge RW0_clk) begin
                if (!RW0_rst_n) begin
                    p_v <= 1'b0;
                    p_d <= '0;
                    RW0_rvalid <= 1'b0;
                    RW0_rdata <= '0;
                end else begin
                    p_v <= rd;
                    if (rd) p_d <= ram[RW0_addr];
                    RW0_rvalid <= p_v;
                    if (p_v) RW0_rdata <= p_d;
                end
            end
        end else begin : g_lat1
            always_ff @(posedge RW0_clk) begin
                if (!RW0_rst_n) begin
                    RW0_rvalid <= 1'b0;
                    RW0_rdata <= '0;
                end else begin
                    RW0_rvalid <= rd;
                    if (rd) RW0_rdata <= ram[RW0_addr];
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_sram_1rw_init_ext.sv
// tb_sram_1rw_init_ext: directed checks of a latency-1 and a latency-2 instance
// driven by identical stimulus.
module tb_sram_1rw_init_ext;
    localparam int AW = 4;
    localparam int DW = 64;
    localparam int MW = 8;
    localparam logic [DW-1:0] IV = 64'hA5A5;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic wmode = 1'b0;
    logic init_req = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [MW-1:0] wmask = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata1, rdata2;
    logic rvalid1, rvalid2, ready1, ready2;
    int n_tests = 0;
    int n_fail = 0;
    always #5 clk = ~clk;

    sram_1rw_init_ext #(.ADDR_W(AW), .DATA_W(DW), .LANE_W(8), .RD_LAT(1), .INIT_VAL(IV)) u_lat1 (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
        .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata1), .RW0_rvalid(rvalid1),
        .RW0_ready(ready1), .init_req(init_req));
    sram_1rw_init_ext #(.ADDR_W(AW), .DATA_W(DW), .LANE_W(8), .RD_LAT(2), .INIT_VAL(IV)) u_lat2 (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
        .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata2), .RW0_rvalid(rvalid2),
        .RW0_ready(ready2), .init_req(init_req));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        en = 1'b1; wmode = 1'b1; addr = a; wdata = d; wmask = m;
        tick();
        en = 1'b0; wmode = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        en = 1'b1; wmode = 1'b0; addr = a;
        tick();
        en = 1'b0;
        check("rd1_valid", rvalid1, 1);
        check("rd1_data", rdata1, exp);
        check("rd2_early", rvalid2, 0);
        tick();
        check("rd2_valid", rvalid2, 1);
        check("rd2_data", rdata2, exp);
        check("rd1_pulse", rvalid1, 0);
    endtask

    task automatic wait_ready(input int start, input int exp);
        int cnt = start;
        logic rv = 1'b0;
        while (!ready2 && cnt < 40) begin
            tick();
            cnt++;
            rv = rv | rvalid1 | rvalid2;
        end
        en = 1'b0;
        check("clr_len", cnt, exp);
        check("clr_rvalid", rv, 0);
        check("clr_ready1", ready1, 1);
    endtask

    initial begin
        logic rv;
        repeat (2) tick();
        check("rst_ready", {ready1, ready2}, 0);
        check("rst_rvalid", {rvalid1, rvalid2}, 0);
        check("rst_rdata1", rdata1, 0);
        check("rst_rdata2", rdata2, 0);
        // write attempt held during the initial clear must be ignored
        en = 1'b1; wmode = 1'b1; addr = 4'd2; wdata = 64'hFF; wmask = 8'hFF;
        rst_n = 1'b1;
        wait_ready(0, 16);
        for (int a = 0; a < 16; a++) rd(AW'(a), IV);
        wr(4'd3, 64'h1122334455667788, 8'h0F);
        rd(4'd3, 64'h0000000055667788);
        wr(4'd4, 64'h1122334455667788, 8'hF0);
        rd(4'd4, 64'h112233440000A5A5);
        wr(4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        rd(4'd6, IV);
        wr(4'd8, 64'hCAFEF00D12345678, 8'hFF);
        rd(4'd8, 64'hCAFEF00D12345678);
        wr(4'd5, 64'h77, 8'hFF);
        rd(4'd5, 64'h77);
        rv = 1'b0;
        repeat (10) begin
            tick();
            rv = rv | rvalid1 | rvalid2;
        end
        wr(4'd5, 64'h99, 8'hFF);
        rv = rv | rvalid1 | rvalid2;
        check("hold_rvalid", rv, 0);
        check("hold_rdata1", rdata1, 64'h77);
        check("hold_rdata2", rdata2, 64'h77);
        rd(4'd5, 64'h99);
        wr(4'd1, 64'h1111, 8'hFF);
        wr(4'd2, 64'h2222, 8'hFF);
        wr(4'd3, 64'h3333, 8'hFF);
        en = 1'b1; wmode = 1'b0; addr = 4'd1;
        tick();
        check("b2b_e1_v1", rvalid1, 1);
        check("b2b_e1_d1", rdata1, 64'h1111);
        check("b2b_e1_v2", rvalid2, 0);
        addr = 4'd2;
        tick();
        check("b2b_e2_d1", rdata1, 64'h2222);
        check("b2b_e2_v2", rvalid2, 1);
        check("b2b_e2_d2", rdata2, 64'h1111);
        addr = 4'd3;
        tick();
        check("b2b_e3_d1", rdata1, 64'h3333);
        check("b2b_e3_v2", rvalid2, 1);
        check("b2b_e3_d2", rdata2, 64'h2222);
        en = 1'b0;
        tick();
        check("b2b_e4_v1", rvalid1, 0);
        check("b2b_e4_v2", rvalid2, 1);
        check("b2b_e4_d2", rdata2, 64'h3333);
        tick();
        check("b2b_e5_v2", rvalid2, 0);
        wr(4'd7, 64'h55, 8'hFF);
        en = 1'b1; wmode = 1'b0; addr = 4'd7; init_req = 1'b1;
        tick();
        init_req = 1'b0; en = 1'b0;
        check("init_ready", ready2, 0);
        check("init_rd1_v", rvalid1, 1);
        check("init_rd1_d", rdata1, 64'h55);
        tick();
        check("init_rd2_v", rvalid2, 1);
        check("init_rd2_d", rdata2, 64'h55);
        wait_ready(1, 16);
        rd(4'd7, IV);
        rd(4'd3, IV);
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midclr_ready", ready2, 0);
        wait_ready(0, 16);
        rd(4'd0, IV);
        en = 1'b1; wmode = 1'b0; addr = 4'd9;
        tick();
        en = 1'b0; rst_n = 1'b0;
        check("midrd_v1", rvalid1, 1);
        check("midrd_d1", rdata1, IV);
        tick();
        rst_n = 1'b1;
        check("midrd_v2", rvalid2, 0);
        check("midrd_d2", rdata2, 0);
        check("midrd_rst_d1", rdata1, 0);
        wait_ready(0, 16);
        rd(4'd9, IV);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
